// File: rtl/transmisor_pkg.sv
// transmisor_pkg: shared encodings and slot timing for the transmisor scheduler
package transmisor_pkg;
    localparam logic [1:0] DS_8 = 2'b00;
    localparam logic [1:0] DS_16 = 2'b01;
    localparam logic [1:0] DS_32 = 2'b10;
    localparam logic [1:0] GR_IDLE = 2'b00;
    localparam logic [1:0] GR_8 = 2'b01;
    localparam logic [1:0] GR_16 = 2'b10;
    localparam logic [1:0] GR_32 = 2'b11;
    localparam logic [7:0] IDLE_SYM_DEF = 8'hBC;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
    function automatic int slot_len(input logic [1:0] ds, input int byte_cycles);
        return ds == DS_32 ? 4 * byte_cycles : ds == DS_16 ? 2 * byte_cycles : byte_cycles;
    endfunction
endpackage

// File: rtl/transmisor_scheduler_if.sv
// transmisor_scheduler_if: requester handshakes plus the transmitter drive bundle
interface transmisor_scheduler_if;
    logic        req8_valid;
    logic [7:0]  req8_data;
    logic        req8_k;
    logic        req8_ready;
    logic        req16_valid;
    logic [15:0] req16_data;
    logic        req16_ready;
    logic        req32_valid;
    logic [31:0] req32_data;
    logic        req32_ready;
    logic        tx_enb;
    logic        tx_K;
    logic [7:0]  tx_dataIn;
    logic [15:0] tx_dataIn16;
    logic [31:0] tx_dataIn32;
    logic [1:0]  tx_dataS;
    logic [1:0]  grant;
    logic        busy;
    modport slave (
        input  req8_valid, req8_data, req8_k, req16_valid, req16_data, req32_valid, req32_data,
        output req8_ready, req16_ready, req32_ready,
        output tx_enb, tx_K, tx_dataIn, tx_dataIn16, tx_dataIn32, tx_dataS, grant, busy
    );
    modport master (
        output req8_valid, req8_data, req8_k, req16_valid, req16_data, req32_valid, req32_data,
        input  req8_ready, req16_ready, req32_ready,
        input  tx_enb, tx_K, tx_dataIn, tx_dataIn16, tx_dataIn32, tx_dataS, grant, busy
    );
endinterface

// File: rtl/rr_arbiter3.sv
// rr_arbiter3: 3-way combinational round-robin; pointer advances past the winner on en
module rr_arbiter3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       any
);
    logic [1:0] ptr, p1, p2, win;
    function automatic logic [1:0] inc3(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction
    always_comb begin
        p1 = inc3(ptr);
        p2 = inc3(p1);
        any = |req;
        win = req[ptr] ? ptr : req[p1] ? p1 : p2;
        gnt = (en && any) ? 3'b001 << win : 3'b000;
    end
    always_ff @(posedge clk)
        if (rst) ptr <= 2'd0;
        else if (en && any) ptr <= inc3(win);
endmodule

// File: rtl/transmisor_scheduler.sv
// transmisor_scheduler: slot-based round-robin feeder for the transmisor serializer,
// holding each word for its serialization time and filling gaps with comma symbols
module transmisor_scheduler
    import transmisor_pkg::*;
#(
    parameter int         BYTE_CYCLES = 10,
    parameter logic [7:0] IDLE_SYM    = IDLE_SYM_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enb,
    transmisor_scheduler_if.slave bus
);
    localparam int CW = $clog2(4 * BYTE_CYCLES);
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [2:0] gnt;
    logic [1:0] ds_nxt, gr_nxt;
    logic bnd, any;
    assign bnd = enb && !rst && cnt == '0;
    rr_arbiter3 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (bnd),
        .req ({bus.req32_valid, bus.req16_valid, bus.req8_valid}),
        .gnt (gnt),
        .any (any)
    );
    assign bus.req8_ready  = gnt[0];
    assign bus.req16_ready = gnt[1];
    assign bus.req32_ready = gnt[2];
    always_comb begin
        state_nxt = bnd ? ST_RUN : state;
        ds_nxt = gnt[2] ? DS_32 : gnt[1] ? DS_16 : DS_8;
        gr_nxt = gnt[2] ? GR_32 : gnt[1] ? GR_16 : gnt[0] ? GR_8 : GR_IDLE;
    end
    always_ff @(posedge clk)
        state <= rst ? ST_IDLE : state_nxt;
    // unselected data lanes keep their last word so the serializer inputs stay quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt             <= '0;
            bus.tx_enb      <= 1'b0;
            bus.tx_K        <= 1'b0;
            bus.tx_dataIn   <= '0;
            bus.tx_dataIn16 <= '0;
            bus.tx_dataIn32 <= '0;
            bus.tx_dataS    <= DS_8;
            bus.grant       <= GR_IDLE;
            bus.busy        <= 1'b0;
        end else if (bnd) begin
            cnt          <= CW'(slot_len(ds_nxt, BYTE_CYCLES) - 1);
            bus.tx_enb   <= 1'b1;
            bus.tx_K     <= gnt[0] ? bus.req8_k : !any;
            bus.tx_dataS <= ds_nxt;
            bus.grant    <= gr_nxt;
            bus.busy     <= any;
            if (gnt[0] || !any) bus.tx_dataIn <= any ? bus.req8_data : IDLE_SYM;
            if (gnt[1]) bus.tx_dataIn16 <= bus.req16_data;
            if (gnt[2]) bus.tx_dataIn32 <= bus.req32_data;
        end else if (enb && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end
endmodule

// File: tb/tb_transmisor_scheduler.sv
// tb_transmisor_scheduler: directed scenarios then random traffic against a slot-level reference model
module tb_transmisor_scheduler;
    logic clk = 1'b0;
    logic rst, enb;
    always #5 clk = ~clk;
    transmisor_scheduler_if bus();
    transmisor_scheduler dut (.clk(clk), .rst(rst), .enb(enb), .bus(bus));

    int errors = 0, checks = 0, cyc = 0;
    logic [2:0] v = '0, keep = '0, acc, obs;
    logic [7:0] d8 = 8'hCC;
    logic k8 = 1'b0;
    logic [15:0] d16 = 16'hABCD;
    logic [31:0] d32 = 32'h0123456F;
    // reference: remaining enabled cycles to the next slot boundary, pointer, expected drive
    int rem = 0, ptr = 0;
    logic e_enb = 0, e_k = 0, e_busy = 0;
    logic [7:0] e_d8 = 0;
    logic [15:0] e_d16 = 0;
    logic [31:0] e_d32 = 0;
    logic [1:0] e_ds = 0, e_gr = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic cycle();
        int w;
        logic [2:0] er;
        @(negedge clk);
        bus.req8_valid = v[0]; bus.req8_data = d8; bus.req8_k = k8;
        bus.req16_valid = v[1]; bus.req16_data = d16;
        bus.req32_valid = v[2]; bus.req32_data = d32;
        #1;
        w = -1;
        if (enb && !rst && rem == 0)
            for (int o = 2; o >= 0; o--) if (v[(ptr + o) % 3]) w = (ptr + o) % 3;
        er = (w >= 0) ? 3'b001 << w : 3'b000;
        obs = {bus.req32_ready, bus.req16_ready, bus.req8_ready};
        check("ready8", obs[0], er[0]);
        check("ready16", obs[1], er[1]);
        check("ready32", obs[2], er[2]);
        acc = er;
        if (rst) begin
            rem = 0; ptr = 0; e_enb = 0; e_k = 0; e_busy = 0;
            e_d8 = 0; e_d16 = 0; e_d32 = 0; e_ds = 0; e_gr = 0;
        end else if (enb && rem == 0) begin
            e_enb = 1;
            if (w < 0) begin
                e_ds = 0; e_d8 = 8'hBC; e_k = 1; e_gr = 0; e_busy = 0; rem = 9;
            end else begin
                e_ds = 2'(w); e_gr = 2'(w + 1); e_busy = 1; e_k = (w == 0) ? k8 : 1'b0;
                if (w == 0) e_d8 = d8;
                if (w == 1) e_d16 = d16;
                if (w == 2) e_d32 = d32;
                ptr = (w + 1) % 3;
                rem = 10 * (1 << w) - 1;
            end
        end else if (enb && rem > 0) rem--;
        @(posedge clk);
        #1;
        check("tx_enb", bus.tx_enb, e_enb);
        check("tx_K", bus.tx_K, e_k);
        check("tx_dataIn", bus.tx_dataIn, e_d8);
        check("tx_dataIn16", bus.tx_dataIn16, e_d16);
        check("tx_dataIn32", bus.tx_dataIn32, e_d32);
        check("tx_dataS", bus.tx_dataS, e_ds);
        check("grant", bus.grant, e_gr);
        check("busy", bus.busy, e_busy);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            cycle();
            for (int j = 0; j < 3; j++) if (acc[j] && !keep[j]) v[j] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1; run(1); rst = 0;
    endtask

    initial begin
        int t0, gap, n;
        rst = 1; enb = 0;
        run(2);
        rst = 0; enb = 1;
        run(25);
        v = 3'b001; keep = 3'b001;
        run(25);
        v = 3'b000; keep = 3'b000;
        do_reset();
        v = 3'b110;
        run(65);
        v = 3'b001;
        run(15);
        v = 3'b000;
        do_reset();
        v = 3'b111; keep = 3'b111;
        run(150);
        // enable gap inside a 32-bit slot stretches the slot by the gap length
        v = 3'b000; keep = 3'b000;
        do_reset();
        v = 3'b100;
        n = 0;
        do begin run(1); n++; end while (!obs[2] && n < 60);
        t0 = cyc;
        v[0] = 1'b1;
        run(5);
        enb = 0; run(7); enb = 1;
        n = 0;
        do begin run(1); n++; end while (!obs[0] && n < 100);
        gap = cyc - t0;
        check("gap47", gap, 47);
        // reset in the middle of a 16-bit slot
        v = 3'b000;
        do_reset();
        v = 3'b010;
        n = 0;
        do begin run(1); n++; end while (!obs[1] && n < 60);
        run(6);
        v[0] = 1'b1;
        do_reset();
        run(1);
        check("rst_ready8", obs[0], 1'b1);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom % 400) == 0;
            enb = ($urandom % 8) != 0;
            if (!v[0] && $urandom % 3 == 0) begin v[0] = 1; d8 = 8'($urandom); k8 = 1'($urandom); end
            if (!v[1] && $urandom % 3 == 0) begin v[1] = 1; d16 = 16'($urandom); end
            if (!v[2] && $urandom % 3 == 0) begin v[2] = 1; d32 = $urandom; end
            cycle();
            for (int j = 0; j < 3; j++) if (acc[j] && ($urandom % 2 == 0)) v[j] = 1'b0;
            if (acc[0]) begin d8 = 8'($urandom); k8 = 1'($urandom); end
            if (acc[1]) d16 = 16'($urandom);
            if (acc[2]) d32 = $urandom;
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/transmisor_scheduler.md
Name: transmisor_scheduler

Overview:
- Shares the PCIe-style `transmisor` serializer between three requesters: an 8-bit source, a 16-bit source and a 32-bit source.
- Round-robin arbitration happens only at symbol-slot boundaries.
- The block drives the transmitter's `dataIn`/`dataIn16`/`dataIn32`/`dataS`/`K`/`enb` inputs and holds each word for exactly the serialization time.
- When no requester is pending, it inserts comma idle symbols.

Parameters:
BYTE_CYCLES, 10, clk cycles needed to serialize one 10-bit encoded byte
IDLE_SYM, 8'hBC, idle/comma byte (K28.5) sent with K=1 when no request is pending

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
enb  in  1  global enable; when 0, all state freezes
req8_valid  in  1  8-bit requester has data
req8_data  in  8  8-bit payload
req8_k  in  1  payload is a control (K) symbol
req8_ready  out  1  handshake accept, 8-bit
req16_valid  in  1  16-bit requester has data
req16_data  in  16  16-bit payload
req16_ready  out  1  handshake accept, 16-bit
req32_valid  in  1  32-bit requester has data
req32_data  in  32  32-bit payload
req32_ready  out  1  handshake accept, 32-bit
tx_enb  out  1  to transmisor enb
tx_K  out  1  to transmisor K
tx_dataIn  out  8  to transmisor dataIn
tx_dataIn16  out  16  to transmisor dataIn16
tx_dataIn32  out  32  to transmisor dataIn32
tx_dataS  out  2  to transmisor dataS (00=8b, 01=16b, 10=32b)
grant  out  2  current slot owner (00 idle, 01 req8, 10 req16, 11 req32)
busy  out  1  current slot carries requester data (not idle)

Behaviour:
- Reset (rst=1 at posedge): all outputs 0; slot counter `cnt`=0; round-robin pointer points at req8; state IDLE.
- State machine:
  - IDLE: no slot loaded since reset.
  - RUN: a slot is active.
  - Every transition requires enb=1.
- Boundary: a cycle with enb=1 and cnt==0 (in either state).
- Arbitration at a boundary:
  - Rotating priority starting at the pointer; order is 8→16→32→8.
  - The winner's `reqX_ready` is asserted combinationally in the boundary cycle only.
  - A transfer occurs when valid&ready; valid must not drop before ready.
  - At most one ready is high per cycle.
  - ready is never high outside a boundary, nor while enb=0 or rst=1.
- Load on the boundary posedge when a requester wins:
  - tx_dataS, the matching tx_data* and grant are set; busy=1.
  - Non-selected tx_data* keep their previous values.
  - tx_K=req8_k for 8-bit slots, else 0.
  - Pointer moves to the requester after the winner.
- Idle load on a boundary with no valid requester:
  - tx_dataS=00, tx_dataIn=IDLE_SYM, tx_K=1, grant=00, busy=0.
  - Pointer unchanged.
- Slot length L: BYTE_CYCLES for 8b/idle, 2*BYTE_CYCLES for 16b, 4*BYTE_CYCLES for 32b.
- Counter:
  - On load, cnt=L-1.
  - Each later enb=1 cycle decrements cnt.
  - The next boundary is exactly L enabled cycles after the load.
  - cnt width is clog2(4*BYTE_CYCLES).
- tx_enb: set to 1 on the first load after reset, then held at 1 until rst.
- enb=0 mid-slot: cnt, pointer and all outputs hold; no ready.
- Reset mid-slot: slot abandoned; the accepted word is not retransmitted; next boundary follows the first enb=1 cycle after reset.
- Simultaneous valid at a boundary: only the pointer-order winner gets ready; the others wait for a later boundary.
- A requester asserting valid mid-slot waits for the next boundary; ready latency is ≤ 4*BYTE_CYCLES cycles plus arbitration delay from the other two requesters.
- First boundary after reset: the first enb=1 cycle in state IDLE.

Decomposition:
- Shared package `transmisor_pkg`:
  - dataS constants DS_8=2'b00, DS_16=2'b01, DS_32=2'b10.
  - grant encodings GR_IDLE/GR_8/GR_16/GR_32.
  - IDLE_SYM default.
  - slot-length function of dataS and BYTE_CYCLES.
- One sub-module: `rr_arbiter3`.
  - 3-request combinational round-robin with a registered pointer.
  - Pointer update enabled by the boundary strobe.

Test Plan:
- Reset then enb=1, no valid → tx_K=1, tx_dataIn=8'hBC, tx_dataS=00 reloaded every 10 cycles; grant=00, busy=0, all ready=0.
- req8_valid with data 8'hCC, k=0 held → ready pulses at the boundary; next cycle tx_dataIn=8'hCC, tx_dataS=00, tx_K=0; next ready exactly 10 cycles later.
- req16 with 16'hABCD and req32 with 32'h0123456F asserted together, pointer at req8 → req16 wins, slot of 20 cycles; then req32, tx_dataS=10, slot of 40 cycles; then the pointer returns to req8.
- All three valid continuously → grant sequence 01,10,11,01… with ready spacing 10,20,40 cycles; no two readies in the same cycle.
- enb dropped for 7 cycles in the middle of a 32-bit slot → outputs frozen; next boundary arrives 47 cycles after the load.
- rst asserted mid 16-bit slot → next cycle all outputs 0; after rst release with enb=1, first boundary on the first enabled cycle; a pending req8 gets ready there.
